// File: rtl/fp_align_unit_if.sv
// fp_align_unit_if: operand/result bus of the FP adder front end.
interface fp_align_unit_if;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] A, B, A_o, B_o, alignedResult;
   logic        signA, signB, ANaN, BNaN, Ainf, Binf, Azero, Bzero, Asub, Bsub;
   logic        alignedSign, carryOut, sticky;
   logic [7:0]  exponentOut;
   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, A_o, B_o, alignedResult, signA, signB, ANaN, BNaN,
             Ainf, Binf, Azero, Bzero, Asub, Bsub, alignedSign, carryOut, sticky, exponentOut
   );
   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, A_o, B_o, alignedResult, signA, signB, ANaN, BNaN,
             Ainf, Binf, Azero, Bzero, Asub, Bsub, alignedSign, carryOut, sticky, exponentOut
   );
endinterface

// File: rtl/fp_align_unit.sv
// fp_align_unit: FP adder front end - unpack, swap, one-bit-per-cycle align, effective add/sub.
module fp_align_unit #(
   parameter int MAX_SHIFT = 32
) (
   input logic            clk,
   input logic            rst_n,
   fp_align_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, ADD, DONE} state_t;
   localparam logic [7:0] maxShift = 8'(MAX_SHIFT);
   state_t      state, nextState;
   logic [1:0]  rstSync;
   logic        rstInt_n;
   logic [7:0]  diff, expL, expA, expB, effA, effB, diffIn;
   logic [31:0] sigL, sigS, sigA, sigB, sigSm;
   logic        stickyR, signL, special, bothSub;
   logic        nanA, nanB, infA, infB, zeroA, zeroB, subA, subB;
   logic        aLarger, isSpecial, clamp, effSub;
   logic [32:0] sum;
   // reset asserts asynchronously but releases on a clock edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rstSync <= 2'b00;
      else rstSync <= {rstSync[0], 1'b1};
   assign rstInt_n = rstSync[1];
   assign expA = bus.A[30:23];
   assign expB = bus.B[30:23];
   assign effA = expA == 8'd0 ? 8'd1 : expA;
   assign effB = expB == 8'd0 ? 8'd1 : expB;
   assign sigA = {expA != 8'd0, bus.A[22:0], 8'b0};
   assign sigB = {expB != 8'd0, bus.B[22:0], 8'b0};
   assign nanA = &expA & |bus.A[22:0];
   assign nanB = &expB & |bus.B[22:0];
   assign infA = &expA & ~|bus.A[22:0];
   assign infB = &expB & ~|bus.B[22:0];
   assign zeroA = ~|bus.A[30:0];
   assign zeroB = ~|bus.B[30:0];
   assign subA = ~|expA & |bus.A[22:0];
   assign subB = ~|expB & |bus.B[22:0];
   assign aLarger = bus.A[30:0] >= bus.B[30:0];
   assign diffIn = aLarger ? effA - effB : effB - effA;
   assign sigSm = aLarger ? sigB : sigA;
   assign isSpecial = |{nanA, nanB, infA, infB, zeroA, zeroB};
   assign clamp = diffIn >= maxShift;
   assign effSub = bus.signA ^ bus.signB;
   // L >= S|sticky always holds, so the subtract never borrows
   assign sum = effSub ? {1'b0, sigL} - {1'b0, sigS | {31'b0, stickyR}} : {1'b0, sigL} + {1'b0, sigS};
   assign bus.in_ready = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.sticky = stickyR;
   always_ff @(posedge clk or negedge rstInt_n)
      if (!rstInt_n) state <= IDLE;
      else state <= nextState;
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.in_valid) nextState = (isSpecial || clamp || diffIn == 8'd0) ? ADD : SHIFT;
         SHIFT:   if (diff == 8'd1) nextState = ADD;
         ADD:     nextState = DONE;
         DONE:    if (bus.out_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstInt_n)
      if (!rstInt_n) begin
         bus.A_o <= '0;
         bus.B_o <= '0;
         bus.signA <= 1'b0;
         bus.signB <= 1'b0;
         {bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf, bus.Azero, bus.Bzero, bus.Asub, bus.Bsub} <= '0;
         bus.alignedSign <= 1'b0;
         bus.alignedResult <= '0;
         bus.carryOut <= 1'b0;
         bus.exponentOut <= '0;
         diff <= '0;
         expL <= '0;
         sigL <= '0;
         sigS <= '0;
         stickyR <= 1'b0;
         signL <= 1'b0;
         special <= 1'b0;
         bothSub <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         bus.A_o <= bus.A;
         bus.B_o <= bus.B;
         bus.signA <= bus.A[31];
         bus.signB <= bus.B[31];
         {bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf, bus.Azero, bus.Bzero, bus.Asub, bus.Bsub} <=
            {nanA, nanB, infA, infB, zeroA, zeroB, subA, subB};
         diff <= diffIn;
         expL <= aLarger ? effA : effB;
         signL <= aLarger ? bus.A[31] : bus.B[31];
         sigL <= aLarger ? sigA : sigB;
         sigS <= (!isSpecial && clamp) ? 32'd0 : sigSm;
         stickyR <= !isSpecial && clamp && |sigSm;
         special <= isSpecial;
         bothSub <= subA && subB;
      end else if (state == SHIFT) begin
         sigS <= sigS >> 1;
         stickyR <= stickyR | sigS[0];
         diff <= diff - 8'd1;
      end else if (state == ADD) begin
         bus.alignedResult <= special ? 32'd0 : sum[31:0];
         bus.carryOut <= special ? 1'b0 : bothSub ? sum[31] : sum[32];
         bus.alignedSign <= (!special && sum == 33'd0) ? 1'b0 : signL;
         bus.exponentOut <= bothSub ? 8'd0 : expL;
      end
endmodule

// File: tb/tb_fp_align_unit.sv
// tb_fp_align_unit: directed and randomized checks of fp_align_unit against an arithmetic model.
module tb_fp_align_unit;
   typedef struct {
      logic [31:0] res;
      logic        carry, sgn, stk, special;
      logic [7:0]  ex;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fp_align_unit_if bus();
   fp_align_unit #(.MAX_SHIFT(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [3:0] cls(input logic [31:0] x);
      return {x[30:23] == 8'hFF && x[22:0] != 23'd0, x[30:23] == 8'hFF && x[22:0] == 23'd0,
              x[30:0] == 31'd0, x[30:23] == 8'd0 && x[22:0] != 23'd0};
   endfunction

   function automatic logic [7:0] flagsOf(input logic [31:0] a, input logic [31:0] b);
      logic [3:0] ca, cb;
      ca = cls(a);
      cb = cls(b);
      return {ca[3], cb[3], ca[2], cb[2], ca[1], cb[1], ca[0], cb[0]};
   endfunction

   // value-level model: shift by the whole difference at once, sticky from the lost bits
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t r;
      logic [63:0] eA, eB, mA, mB, eL, eS, mL, mS, d, al, stk, sum;
      logic aBig, sgnL, sub;
      logic [3:0] ca, cb;
      ca = cls(a);
      cb = cls(b);
      eA = 64'(a[30:23] == 8'd0 ? 8'd1 : a[30:23]);
      eB = 64'(b[30:23] == 8'd0 ? 8'd1 : b[30:23]);
      mA = 64'({a[30:23] != 8'd0, a[22:0]}) << 8;
      mB = 64'({b[30:23] != 8'd0, b[22:0]}) << 8;
      aBig = a[30:0] >= b[30:0];
      eL = aBig ? eA : eB;
      eS = aBig ? eB : eA;
      mL = aBig ? mA : mB;
      mS = aBig ? mB : mA;
      sgnL = aBig ? a[31] : b[31];
      sub = a[31] != b[31];
      d = eL - eS;
      if (d >= 64'd32) begin
         al = 64'd0;
         stk = 64'(mS != 64'd0);
      end else begin
         al = mS >> d;
         stk = 64'((mS & ((64'd1 << d) - 64'd1)) != 64'd0);
      end
      sum = sub ? mL - (al | stk) : mL + al;
      r.res = sum[31:0];
      r.carry = sub ? 1'b0 : sum[32];
      r.sgn = (sum == 64'd0) ? 1'b0 : sgnL;
      r.ex = eL[7:0];
      r.stk = stk[0];
      r.lat = (d == 64'd0 || d >= 64'd32) ? 1 : int'(d) + 1;
      r.special = |(ca[3:1] | cb[3:1]);
      if (ca[0] && cb[0]) begin
         r.ex = 8'd0;
         r.carry = sum[31];
      end
      if (r.special) begin
         r.res = 32'd0;
         r.stk = 1'b0;
         r.lat = 1;
      end
      return r;
   endfunction

   function automatic logic [127:0] snap();
      return 128'({bus.A_o, bus.B_o, bus.alignedResult, bus.exponentOut, bus.carryOut, bus.sticky,
                   bus.alignedSign, bus.signA, bus.signB, bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf,
                   bus.Azero, bus.Bzero, bus.Asub, bus.Bsub});
   endfunction

   function automatic logic [7:0] dutFlags();
      return {bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf, bus.Azero, bus.Bzero, bus.Asub, bus.Bsub};
   endfunction

   task automatic releaseOut();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      check("released", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
   endtask

   task automatic doOp(input logic [31:0] a, input logic [31:0] b, input bit hold, output int latOut);
      exp_t e;
      int lat;
      e = model(a, b);
      lat = 0;
      @(negedge clk);
      check("in_ready", 128'(bus.in_ready), 128'(1'b1));
      bus.A = a;
      bus.B = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      while (!bus.out_valid && lat < 300) begin
         @(posedge clk);
         lat++;
         #1;
      end
      latOut = lat;
      check("latency", 128'(lat), 128'(e.lat));
      check("operands", 128'({bus.A_o, bus.B_o}), 128'({a, b}));
      check("signs", 128'({bus.signA, bus.signB}), 128'({a[31], b[31]}));
      check("flags", 128'(dutFlags()), 128'(flagsOf(a, b)));
      check("result", 128'(bus.alignedResult), 128'(e.res));
      check("sticky", 128'(bus.sticky), 128'(e.stk));
      if (!e.special) begin
         check("carry", 128'(bus.carryOut), 128'(e.carry));
         check("exponent", 128'(bus.exponentOut), 128'(e.ex));
         check("sign", 128'(bus.alignedSign), 128'(e.sgn));
      end
      if (!hold) releaseOut();
   endtask

   task automatic expectFields(input string t, input logic [31:0] res, input logic c,
                               input logic [7:0] ex, input logic st, input logic sg);
      check({t, ".res"}, 128'(bus.alignedResult), 128'(res));
      check({t, ".carry"}, 128'(bus.carryOut), 128'(c));
      check({t, ".exp"}, 128'(bus.exponentOut), 128'(ex));
      check({t, ".sticky"}, 128'(bus.sticky), 128'(st));
      check({t, ".sign"}, 128'(bus.alignedSign), 128'(sg));
   endtask

   initial begin
      logic [31:0] a, b;
      logic [127:0] s;
      int lat, k;
      bit sawValid;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.A = '0;
      bus.B = '0;
      repeat (3) @(negedge clk);
      check("reset.handshake", 128'({bus.in_ready, bus.out_valid}), 128'(2'b10));
      check("reset.fields", snap(), 128'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      doOp(32'h3F800000, 32'h3F800000, 1'b1, lat);
      check("one_plus_one.lat", 128'(lat), 128'(1));
      expectFields("one_plus_one", 32'h00000000, 1'b1, 8'h7F, 1'b0, 1'b0);
      releaseOut();
      doOp(32'h3F800000, 32'h3F000000, 1'b1, lat);
      check("one_plus_half.lat", 128'(lat), 128'(2));
      expectFields("one_plus_half", 32'hC0000000, 1'b0, 8'h7F, 1'b0, 1'b0);
      releaseOut();
      doOp(32'h40000000, 32'hBF800000, 1'b1, lat);
      check("two_minus_one.lat", 128'(lat), 128'(2));
      expectFields("two_minus_one", 32'h40000000, 1'b0, 8'h80, 1'b0, 1'b0);
      releaseOut();
      doOp(32'h3F800000, 32'hBF800000, 1'b1, lat);
      expectFields("cancel", 32'h00000000, 1'b0, 8'h7F, 1'b0, 1'b0);
      releaseOut();
      doOp(32'h3F800000, 32'h30400000, 1'b1, lat);
      check("diff31.lat", 128'(lat), 128'(32));
      expectFields("diff31", 32'h80000001, 1'b0, 8'h7F, 1'b1, 1'b0);
      releaseOut();
      doOp(32'h3F800000, 32'h2F000000, 1'b1, lat);
      check("diff33.lat", 128'(lat), 128'(1));
      expectFields("diff33", 32'h80000000, 1'b0, 8'h7F, 1'b1, 1'b0);
      releaseOut();
      doOp(32'h7FC00000, 32'h3F800000, 1'b1, lat);
      check("nan.lat", 128'(lat), 128'(1));
      check("nan.flag", 128'(bus.ANaN), 128'(1'b1));
      check("nan.res", 128'(bus.alignedResult), 128'(32'd0));
      check("nan.A_o", 128'(bus.A_o), 128'(32'h7FC00000));
      releaseOut();
      doOp(32'h00000000, 32'h3F800000, 1'b1, lat);
      check("zero.flag", 128'(bus.Azero), 128'(1'b1));
      releaseOut();

      // result held while downstream stalls; new operands ignored
      doOp(32'h3F800000, 32'h3F000000, 1'b1, lat);
      s = snap();
      @(negedge clk);
      bus.A = 32'h40400000;
      bus.B = 32'h40800000;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold.valid", 128'({bus.out_valid, bus.in_ready}), 128'(2'b10));
         check("hold.fields", snap(), s);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      check("handshake.idle", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
      check("handshake.noaccept", 128'(bus.A_o), 128'(32'h3F800000));
      bus.in_valid = 1'b0;

      // reset in the middle of a long shift
      @(negedge clk);
      bus.A = 32'h3F800000;
      bus.B = 32'h30400000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort.handshake", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
      check("abort.fields", snap(), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         sawValid |= bus.out_valid;
      end
      check("abort.noresult", 128'(sawValid), 128'(1'b0));

      for (int i = 0; i < 80; i++) begin
         a = $urandom;
         b = $urandom;
         k = int'($urandom_range(0, 9));
         if (k < 6) b[30:23] = a[30:23] - 8'($urandom_range(0, 40));
         if (k == 6) begin
            a[30:23] = 8'd0;
            b[30:23] = 8'd0;
         end
         if (k == 7) a[30:23] = 8'hFF;
         if (k == 8) b = a ^ 32'h80000000;
         if (k == 9) b[30:23] = a[30:23];
         doOp(a, b, 1'b0, lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_align_unit.md
# fp_align_unit

Front-end of the FP adder pipeline, feeding the normalization stage and producing every `fpbus` field it consumes. The block:
- accepts two IEEE-754 single-precision operands over a valid/ready handshake;
- classifies and unpacks them, then swaps so the larger magnitude leads;
- aligns the smaller mantissa with an iterative one-bit-per-cycle right shifter that accumulates sticky;
- performs the effective add/subtract and presents the raw aligned sum for renormalization and rounding downstream.

## Interface
Parameters:
- MAX_SHIFT, 32, exponent difference at or above which alignment is skipped (smaller operand fully collapses to sticky).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block idle, can accept
- A, B  in  32  IEEE-754 operands
- out_valid  out  1  result fields valid
- out_ready  in  1  downstream accepts result
- A_o, B_o  out  32  captured operands, passed through for special-case selection
- signA, signB  out  1  operand signs
- ANaN, BNaN, Ainf, Binf, Azero, Bzero, Asub, Bsub  out  1  classification flags (exp FF/frac≠0, exp FF/frac=0, exp 0/frac=0, exp 0/frac≠0)
- alignedSign  out  1  result sign
- alignedResult  out  32  aligned sum; hidden bit at [31], fraction [30:8], guard [7], round [6], extension [5:0]
- carryOut  out  1  bit 32 of the sum
- exponentOut  out  8  effective exponent of the larger operand
- sticky  out  1  OR of all bits shifted below [0]

## Operation
- States: IDLE, SHIFT, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture A and B, classify, and register flags.
  - Build the 32-bit significand {hidden, frac, 8'b0}. hidden=0 for subnormals and zeros. Effective exponent is 1 for subnormals.
  - Operand L is the larger of {exp,frac}; on a tie L=A.
  - diff = expL_eff − expS_eff; sticky cleared.
  - Next state:
    - any NaN/inf/zero flag → ADD, no shift, alignedResult forced 0;
    - diff ≥ MAX_SHIFT → S=0, sticky=(S≠0), then ADD;
    - diff=0 → ADD;
    - otherwise → SHIFT.
- SHIFT:
  - Each cycle: S ← S>>1, sticky |= S[0], diff ← diff−1.
  - Go to ADD on the cycle diff reaches 0.
- ADD:
  - Effective add when signA==signB: {carryOut, alignedResult} = L + S.
  - Otherwise subtract: L − (S | sticky), with sticky jammed into the LSB; carryOut=0.
  - alignedSign = sign of L; exact cancellation forces alignedSign=0.
  - exponentOut = expL_eff. For the Asub&&Bsub case exponentOut=0 and carryOut = sum bit [31] (promotion to normal).
  - Next state: DONE.
- DONE:
  - out_valid=1 and all outputs held stable.
  - On out_ready, go to IDLE. in_ready stays 0 until IDLE is re-entered; new operands are never accepted in the same cycle as the DONE handshake.
- Widths: significands and shifter are 32 bits, the adder is 33 bits, diff is 8 bits unsigned.

## Timing
- Reset (async assert, sync deassert internally) forces:
  - state IDLE;
  - in_ready=1;
  - out_valid=0;
  - all result fields and flags 0.
- Reset mid-SHIFT or in DONE aborts the operation; no partial result is emitted.
- Latency is counted in rising edges from the accepting edge to out_valid high:
  - d+1, where d = diff (1 ≤ diff < MAX_SHIFT);
  - 1 for diff=0, clamped differences, or special operands.
- Worst case: MAX_SHIFT edges.
- in_valid is ignored outside IDLE, and operands are sampled only on the accepting edge.
- out_valid holds indefinitely while out_ready=0. Output fields must not change while out_valid=1.

## Test plan
- **1.0 + 1.0:** A=3F800000, B=3F800000
  - latency 1;
  - carryOut=1, alignedResult=00000000, exponentOut=7F, sticky=0, alignedSign=0.
- **1.0 + 0.5:** A=3F800000, B=3F000000
  - 1 SHIFT cycle, latency 2;
  - alignedResult=C0000000, carryOut=0, exponentOut=7F.
- **2.0 + (−1.0):** A=40000000, B=BF800000
  - latency 2;
  - alignedResult=40000000, carryOut=0, exponentOut=80, alignedSign=0.
  - Separately, A=3F800000, B=BF800000 → alignedResult=0, alignedSign=0.
- **Sticky via shift and clamp:**
  - A=3F800000, B=30400000 (diff 31) → latency 32, alignedResult=80000001, sticky=1.
  - A=3F800000, B=2F000000 (diff 33) → latency 1, alignedResult=80000000, sticky=1.
- **Specials:** A=7FC00000, B=3F800000
  - ANaN=1, latency 1, alignedResult=0, A_o=7FC00000.
  - A=00000000, B=3F800000 → Azero=1.
- **Handshake and reset:**
  - Hold out_ready=0 for 10 cycles: out_valid and fields stay stable, in_ready=0, a new in_valid is ignored.
  - Deassert rst_n during SHIFT: out_valid=0 and in_ready=1 immediately, and no result appears after release.
